// File: rtl/shift_arbiter_pkg.sv
// ============================================================================
// Module  : shift_arbiter_pkg
// Brief   : Shared shift opcodes, requester IDs and helpers for the shift arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_arbiter_pkg;

  localparam int XLEN_SUPPORTED = 32;
  localparam int SHAMT_W        = 5;

  typedef enum logic [1:0] {
    SHIFT_SRL  = 2'b00,
    SHIFT_SLL  = 2'b01,
    SHIFT_SRA  = 2'b10,
    SHIFT_ZERO = 2'b11
  } shift_type_e;

  localparam logic SRC_REQ0 = 1'b0;
  localparam logic SRC_REQ1 = 1'b1;

  // Fill bit for right shifts: only SRA replicates the operand MSB.
  function automatic logic sign_fill(shift_type_e op, logic msb);
    return (op == SHIFT_SRA) && msb;
  endfunction

endpackage : shift_arbiter_pkg

`default_nettype wire

// File: rtl/shift_arbiter_if.sv
// ============================================================================
// Module  : shift_arbiter_if
// Brief   : Request/response bundle between two shift requesters, the arbiter
//           and the result consumer, plus the redirect flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface shift_arbiter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);

  logic                                 flush;

  logic                                 req0_valid;
  logic                                 req0_ready;
  logic [XLEN-1:0]                      req0_a;
  logic [shift_arbiter_pkg::SHAMT_W-1:0] req0_shamt;
  logic [1:0]                           req0_type;
  logic [TAG_W-1:0]                     req0_tag;

  logic                                 req1_valid;
  logic                                 req1_ready;
  logic [XLEN-1:0]                      req1_a;
  logic [shift_arbiter_pkg::SHAMT_W-1:0] req1_shamt;
  logic [1:0]                           req1_type;
  logic [TAG_W-1:0]                     req1_tag;

  logic                                 rsp_valid;
  logic                                 rsp_ready;
  logic [XLEN-1:0]                      rsp_data;
  logic                                 rsp_src;
  logic [TAG_W-1:0]                     rsp_tag;

  // Requester / consumer side.
  modport master (
    output flush,
    output req0_valid, req0_a, req0_shamt, req0_type, req0_tag,
    input  req0_ready,
    output req1_valid, req1_a, req1_shamt, req1_type, req1_tag,
    input  req1_ready,
    input  rsp_valid, rsp_data, rsp_src, rsp_tag,
    output rsp_ready
  );

  // Arbiter side.
  modport slave (
    input  flush,
    input  req0_valid, req0_a, req0_shamt, req0_type, req0_tag,
    output req0_ready,
    input  req1_valid, req1_a, req1_shamt, req1_type, req1_tag,
    output req1_ready,
    output rsp_valid, rsp_data, rsp_src, rsp_tag,
    input  rsp_ready
  );

endinterface : shift_arbiter_if

`default_nettype wire

// File: rtl/shift_arbiter_core.sv
// ============================================================================
// Module  : shift_arbiter_core
// Brief   : Combinational barrel shifter (SRL / SLL / SRA / zero).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter_core
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_SUPPORTED
) (
  input  logic [XLEN-1:0]    i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [1:0]         i_op,
  output logic [XLEN-1:0]    o_r
);

  shift_type_e       w_op;
  logic              w_fill;
  logic [2*XLEN-1:0] w_ext;
  logic [XLEN-1:0]   w_right;

  assign w_op   = shift_type_e'(i_op);
  assign w_fill = sign_fill(w_op, i_a[XLEN-1]);

  // SRL and SRA share one right shifter; the upper half carries the fill bit.
  assign w_ext   = {{XLEN{w_fill}}, i_a};
  assign w_right = XLEN'(w_ext >> i_shamt);

  always_comb begin
    o_r = '0;
    case (w_op)
      SHIFT_SRL,
      SHIFT_SRA:  o_r = w_right;
      SHIFT_SLL:  o_r = i_a << i_shamt;
      SHIFT_ZERO: o_r = '0;
      default:    o_r = '0;
    endcase
  end

endmodule : shift_arbiter_core

`default_nettype wire

// File: rtl/shift_arbiter.sv
// ============================================================================
// Module  : shift_arbiter
// Brief   : Two-requester arbiter in front of one shared barrel shifter with a
//           1-entry registered result stage. SHIFT_ARB_RR_EN selects
//           round-robin grant; otherwise req0 has fixed priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int XLEN  = XLEN_SUPPORTED,
  parameter int TAG_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);

  logic               w_can_accept;
  logic               w_any_valid;
  logic               w_accept;
  logic               w_grant;
  logic [XLEN-1:0]    w_a;
  logic [SHAMT_W-1:0] w_shamt;
  logic [1:0]         w_op;
  logic [TAG_W-1:0]   w_tag;
  logic [XLEN-1:0]    w_result;

  logic               r_rsp_valid;
  logic [XLEN-1:0]    r_rsp_data;
  logic               r_rsp_src;
  logic [TAG_W-1:0]   r_rsp_tag;

  // The output slot frees up in the same cycle it drains; flush blocks all.
  assign w_can_accept = rst_n && !bus.flush && (!r_rsp_valid || bus.rsp_ready);
  assign w_any_valid  = bus.req0_valid || bus.req1_valid;
  assign w_accept     = w_can_accept && w_any_valid;

`ifdef SHIFT_ARB_RR_EN
  logic r_last_grant;

  always_comb begin
    w_grant = SRC_REQ0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (bus.req1_valid) begin
      w_grant = SRC_REQ1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= SRC_REQ1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end
`else
  assign w_grant = (bus.req1_valid && !bus.req0_valid) ? SRC_REQ1 : SRC_REQ0;
`endif

  // Ready is qualified by valid so an idle requester never sees a grant.
  assign bus.req0_ready = w_can_accept && bus.req0_valid && (w_grant == SRC_REQ0);
  assign bus.req1_ready = w_can_accept && bus.req1_valid && (w_grant == SRC_REQ1);

  always_comb begin
    w_a     = bus.req0_a;
    w_shamt = bus.req0_shamt;
    w_op    = bus.req0_type;
    w_tag   = bus.req0_tag;
    if (w_grant == SRC_REQ1) begin
      w_a     = bus.req1_a;
      w_shamt = bus.req1_shamt;
      w_op    = bus.req1_type;
      w_tag   = bus.req1_tag;
    end
  end

  shift_arbiter_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_a     (w_a),
    .i_shamt (w_shamt),
    .i_op    (w_op),
    .o_r     (w_result)
  );

  // Flush only clears valid; the payload registers may keep stale values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_src   <= SRC_REQ0;
      r_rsp_tag   <= '0;
    end else if (bus.flush) begin
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_result;
      r_rsp_src   <= w_grant;
      r_rsp_tag   <= w_tag;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_src   = r_rsp_src;
  assign bus.rsp_tag   = r_rsp_tag;

endmodule : shift_arbiter

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
// ============================================================================
// Module  : tb_shift_arbiter
// Brief   : Directed + random scoreboard bench for shift_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_arbiter_if #(.XLEN(32), .TAG_W(4)) bus ();

  shift_arbiter #(.XLEN(32), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        src;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb[$];
  int          n_checks  = 0;
  int          n_pass    = 0;
  int          exp_r0    = -1;
  int          exp_r1    = -1;
  int          exp_rv    = -1;
  int          exp_dv    = 0;
  logic [31:0] exp_d     = '0;
  logic        prev_rst_n = 1'b0;

  // Bit-by-bit reference shifter.
  function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] sh, logic [1:0] op);
    logic [31:0] r;
    int s;
    r = '0;
    s = int'(sh);
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   r[i] = (i + s < 32) ? a[i+s] : 1'b0;
        2'b01:   r[i] = (i >= s) ? a[i-s] : 1'b0;
        2'b10:   r[i] = (i + s < 32) ? a[i+s] : a[31];
        default: r[i] = 1'b0;
      endcase
    end
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_req(int n, logic v, logic [31:0] a, logic [4:0] sh, logic [1:0] op, logic [3:0] tag);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_a = a; bus.req0_shamt = sh; bus.req0_type = op; bus.req0_tag = tag;
    end else begin
      bus.req1_valid = v; bus.req1_a = a; bus.req1_shamt = sh; bus.req1_type = op; bus.req1_tag = tag;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, '0, '0, 2'b00, '0);
    set_req(1, 1'b0, '0, '0, 2'b00, '0);
  endtask

  // One clock: sample/check at negedge, then advance to just after posedge.
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("rst_req0_ready", bus.req0_ready, 0);
      check("rst_req1_ready", bus.req1_ready, 0);
      if (!prev_rst_n) begin
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_src", bus.rsp_src, 0);
        check("rst_rsp_tag", bus.rsp_tag, 0);
      end
      sb.delete();
    end else begin
      if (exp_r0 >= 0) check("req0_ready", bus.req0_ready, exp_r0);
      if (exp_r1 >= 0) check("req1_ready", bus.req1_ready, exp_r1);
      if (exp_rv >= 0) check("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_dv != 0) check("rsp_data_direct", bus.rsp_data, exp_d);
      check("ready_onehot", bus.req0_ready & bus.req1_ready, 0);
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else if (bus.flush) begin
          void'(sb.pop_front());
        end else begin
          e = sb[0];
          check("rsp_data", bus.rsp_data, e.data);
          check("rsp_src", bus.rsp_src, e.src);
          check("rsp_tag", bus.rsp_tag, e.tag);
          if (bus.rsp_ready) void'(sb.pop_front());
        end
      end
      if (bus.req0_valid && bus.req0_ready) begin
        e.data = ref_shift(bus.req0_a, bus.req0_shamt, bus.req0_type);
        e.src  = 1'b0;
        e.tag  = bus.req0_tag;
        sb.push_back(e);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        e.data = ref_shift(bus.req1_a, bus.req1_shamt, bus.req1_type);
        e.src  = 1'b1;
        e.tag  = bus.req1_tag;
        sb.push_back(e);
      end
    end
    prev_rst_n = rst_n;
    exp_r0 = -1; exp_r1 = -1; exp_rv = -1; exp_dv = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with both requesters valid.
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(0, 1'b1, 32'h1234_5678, 5'd3, 2'b00, 4'd1);
    set_req(1, 1'b1, 32'h8765_4321, 5'd7, 2'b01, 4'd2);
    cyc();
    cyc();
    rst_n = 1'b1;
    idle();
    exp_rv = 0;
    cyc();

    // Lone req1 right after reset is granted immediately.
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 2'b00, 4'd9);
    exp_r0 = 0; exp_r1 = 1; exp_rv = 0;
    cyc();

    // Directed arithmetic on req0, one request per cycle.
    set_req(1, 1'b0, '0, '0, 2'b00, '0);
    set_req(0, 1'b1, 32'h8000_0000, 5'd4, 2'b10, 4'd1);
    exp_r0 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'h0000_000F;
    cyc();
    set_req(0, 1'b1, 32'h8000_0000, 5'd4, 2'b00, 4'd2);
    exp_r0 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'hF800_0000;
    cyc();
    set_req(0, 1'b1, 32'h0000_0001, 5'd31, 2'b01, 4'd3);
    exp_r0 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'h0800_0000;
    cyc();
    set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd0, 2'b11, 4'd4);
    exp_r0 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'h8000_0000;
    cyc();
    set_req(0, 1'b1, 32'hC0DE_CAFE, 5'd0, 2'b00, 4'd5);
    exp_r0 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'h0000_0000;
    cyc();

    // Lone req1 so the last grant points at req1 again.
    set_req(0, 1'b0, '0, '0, 2'b00, '0);
    set_req(1, 1'b1, 32'hF000_0001, 5'd1, 2'b10, 4'd6);
    exp_r1 = 1; exp_rv = 1; exp_dv = 1; exp_d = 32'hC0DE_CAFE;
    cyc();

    // Both valid continuously: alternation under round-robin.
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i));
      set_req(1, 1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(i + 8));
`ifdef SHIFT_ARB_RR_EN
      exp_r0 = (i % 2 == 0) ? 1 : 0;
      exp_r1 = (i % 2 == 1) ? 1 : 0;
`else
      exp_r0 = 1;
      exp_r1 = 0;
`endif
      exp_rv = 1;
      cyc();
    end

    // Stall: result pending with consumer not ready for three cycles.
    set_req(1, 1'b0, '0, '0, 2'b00, '0);
    set_req(0, 1'b1, 32'h00FF_0000, 5'd8, 2'b00, 4'd3);
    exp_r0 = 1; exp_rv = 1;
    cyc();
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, 32'hA5A5_A5A5, 5'd2, 2'b10, 4'd7);
    for (int i = 0; i < 3; i++) begin
      exp_r0 = 0; exp_r1 = 0; exp_rv = 1; exp_dv = 1; exp_d = 32'h0000_FF00;
      cyc();
    end
    bus.rsp_ready = 1'b1;
`ifdef SHIFT_ARB_RR_EN
    exp_r0 = 0; exp_r1 = 1;
`else
    exp_r0 = 1; exp_r1 = 0;
`endif
    exp_rv = 1;
    cyc();

    // Flush with a held result, both valid, consumer ready.
    bus.flush = 1'b1;
    exp_r0 = 0; exp_r1 = 0; exp_rv = 1;
    cyc();
    bus.flush = 1'b0;
    exp_r0 = 1; exp_r1 = 0; exp_rv = 0;
    cyc();
`ifdef SHIFT_ARB_RR_EN
    exp_r0 = 0; exp_r1 = 1;
`else
    exp_r0 = 1; exp_r1 = 0;
`endif
    exp_rv = 1;
    cyc();

    // Random traffic with occasional stalls and flushes.
    for (int i = 0; i < 40; i++) begin
      set_req(0, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      set_req(1, 1'($urandom_range(0, 1)), $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 7) == 0);
      cyc();
    end
    bus.flush = 1'b0;

    // Reset while a result is held: it is discarded.
    bus.rsp_ready = 1'b1;
    idle();
    set_req(0, 1'b1, 32'h0000_F00D, 5'd1, 2'b01, 4'd2);
    exp_r0 = 1;
    cyc();
    idle();
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    exp_rv = 0;
    cyc();

    for (int i = 0; i < 3; i++) cyc();
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_shift_arbiter

`default_nettype wire
